// File: rtl/irq_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_access_sequencer
// Description : Arbitrates CAN event pulses and CPU writes onto the 16-bit
//               interrupt register and derives the active-low host interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_access_sequencer #(
  parameter logic RR_EN   = 1'b1,
  parameter logic IRQ_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_status,
  input  logic        ev_suctra,
  input  logic        ev_sucrec,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_wdata,
  input  logic [15:0] reg_q,
  output logic        can,
  output logic        irqstatusc,
  output logic        irqsuctrac,
  output logic        irqsucrecc,
  output logic        cpu,
  output logic        onoffnin,
  output logic        iestatusp,
  output logic        iesuctrap,
  output logic        iesucrecp,
  output logic        irqstatusp,
  output logic        irqsuctrap,
  output logic        irqsucrecp,
  output logic        cpu_busy,
  output logic        cpu_err,
  output logic        ev_ovr,
  output logic        irq_n
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_CAN_GNT = 2'd1;
  localparam logic [1:0] c_CPU_GNT = 2'd2;
  localparam logic [1:0] c_GAP     = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [2:0] r_pend;
  logic [2:0] r_snap;
  logic       r_last_can;
  logic       r_cpu_busy;
  logic [6:0] r_cpu_data;
  logic       r_cpu_err;
  logic       r_ev_ovr;

  logic [2:0] w_ev;
  logic [2:0] w_clr;
  logic       w_can_go;
  logic       w_cpu_go;
  logic       w_take_can;
  logic       w_take_cpu;
  logic       w_irq;
  logic       w_can_act;
  logic       w_cpu_act;
  logic       w_unused;

  assign w_ev = {ev_status, ev_suctra, ev_sucrec};

  // Round-robin: CAN wins unless the CPU is waiting and CAN had the last slot.
  assign w_can_go = (|r_pend) && (!r_cpu_busy || !RR_EN || !r_last_can);
  assign w_cpu_go = r_cpu_busy && ((r_pend == 3'b000) || (RR_EN && r_last_can));

  always_comb begin
    w_state_nxt = r_state;
    w_take_can  = 1'b0;
    w_take_cpu  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_can_go) begin
          w_state_nxt = c_CAN_GNT;
          w_take_can  = 1'b1;
        end else if (w_cpu_go) begin
          w_state_nxt = c_CPU_GNT;
          w_take_cpu  = 1'b1;
        end
      end
      c_CAN_GNT: w_state_nxt = c_GAP;
      c_CPU_GNT: w_state_nxt = c_GAP;
      c_GAP:     w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // The snapshot taken on CAN grant clears exactly the bits it captured.
  assign w_clr = w_take_can ? r_pend : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_pend     <= 3'b000;
      r_snap     <= 3'b000;
      r_last_can <= 1'b0;
      r_ev_ovr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= (r_pend & ~w_clr) | w_ev;
      r_ev_ovr <= |(w_ev & r_pend & ~w_clr);
      if (w_take_can) begin
        r_snap     <= r_pend;
        r_last_can <= 1'b1;
      end else if (w_take_cpu) begin
        r_last_can <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_busy <= 1'b0;
      r_cpu_data <= 7'd0;
      r_cpu_err  <= 1'b0;
    end else begin
      r_cpu_err <= cpu_wr & r_cpu_busy;
      if (cpu_wr && !r_cpu_busy) begin
        r_cpu_busy <= 1'b1;
        r_cpu_data <= {cpu_wdata[15], cpu_wdata[6:4], cpu_wdata[2:0]};
      end else if (r_state == c_CPU_GNT) begin
        r_cpu_busy <= 1'b0;
      end
    end
  end

  assign w_can_act = (r_state == c_CAN_GNT);
  assign w_cpu_act = (r_state == c_CPU_GNT);

  assign can        = w_can_act;
  assign irqstatusc = w_can_act & r_snap[2];
  assign irqsuctrac = w_can_act & r_snap[1];
  assign irqsucrecc = w_can_act & r_snap[0];

  assign cpu        = w_cpu_act;
  assign onoffnin   = w_cpu_act & r_cpu_data[6];
  assign iestatusp  = w_cpu_act & r_cpu_data[5];
  assign iesuctrap  = w_cpu_act & r_cpu_data[4];
  assign iesucrecp  = w_cpu_act & r_cpu_data[3];
  assign irqstatusp = w_cpu_act & r_cpu_data[2];
  assign irqsuctrap = w_cpu_act & r_cpu_data[1];
  assign irqsucrecp = w_cpu_act & r_cpu_data[0];

  assign cpu_busy = r_cpu_busy;
  assign cpu_err  = r_cpu_err;
  assign ev_ovr   = r_ev_ovr;

  // Interrupt asserted when globally enabled and any enabled flag is set.
  assign w_irq = reg_q[15] & (|(reg_q[6:4] & reg_q[2:0]));

  generate
    if (IRQ_REG) begin : g_irq_reg
      logic r_irq_n;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_irq_n <= 1'b1;
        end else begin
          r_irq_n <= ~w_irq;
        end
      end
      assign irq_n = r_irq_n;
    end else begin : g_irq_comb
      assign irq_n = ~w_irq;
    end
  endgenerate

  assign w_unused = ^{reg_q[14:7], reg_q[3], cpu_wdata[14:7], cpu_wdata[3]};

endmodule
`default_nettype wire

// File: tb/tb_irq_access_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for irq_access_sequencer: directed scenarios plus a
// randomized run compared against a slot-based reference model.
module tb_irq_access_sequencer;

  localparam logic RR_EN = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ev_status = 1'b0, ev_suctra = 1'b0, ev_sucrec = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_wdata = 16'h0, reg_q = 16'h0;
  logic        can, irqstatusc, irqsuctrac, irqsucrecc, cpu;
  logic        onoffnin, iestatusp, iesuctrap, iesucrecp;
  logic        irqstatusp, irqsuctrap, irqsucrecp;
  logic        cpu_busy, cpu_err, ev_ovr, irq_n;

  int checks = 0;
  int fails  = 0;

  irq_access_sequencer #(.RR_EN(RR_EN), .IRQ_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ev_status(ev_status), .ev_suctra(ev_suctra), .ev_sucrec(ev_sucrec),
    .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .reg_q(reg_q),
    .can(can), .irqstatusc(irqstatusc), .irqsuctrac(irqsuctrac), .irqsucrecc(irqsucrecc),
    .cpu(cpu), .onoffnin(onoffnin), .iestatusp(iestatusp), .iesuctrap(iesuctrap),
    .iesucrecp(iesucrecp), .irqstatusp(irqstatusp), .irqsuctrap(irqsuctrap),
    .irqsucrecp(irqsucrecp), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
    .ev_ovr(ev_ovr), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  logic [15:0] act;
  assign act = {can, irqstatusc, irqsuctrac, irqsucrecc, cpu,
                onoffnin, iestatusp, iesuctrap, iesucrecp, irqstatusp, irqsuctrap, irqsucrecp,
                cpu_busy, cpu_err, ev_ovr, irq_n};

  // Reference model: the arbiter offers a slot, a grant reserves three cycles.
  logic [2:0]  m_pend, m_snap;
  logic        m_busy, m_last_can, m_err, m_ovr, m_irq_n;
  logic [15:0] m_buf;
  int          m_wait;
  int          m_cur;   // 0 none, 1 CAN strobe this cycle, 2 CPU strobe this cycle

  task automatic model_reset();
    m_pend = 3'b0; m_snap = 3'b0; m_busy = 1'b0; m_last_can = 1'b0;
    m_err = 1'b0; m_ovr = 1'b0; m_irq_n = 1'b1; m_buf = 16'h0;
    m_wait = 0; m_cur = 0;
  endtask

  task automatic model_edge(input logic [2:0] ev, input logic wr,
                            input logic [15:0] wd, input logic [15:0] rq);
    int         grant;
    logic [2:0] taken;
    grant = 0;
    if (m_wait == 0) begin
      if (m_pend != 3'b0 && (!m_busy || !RR_EN || !m_last_can)) grant = 1;
      else if (m_busy) grant = 2;
    end else begin
      m_wait = m_wait - 1;
    end
    taken = (grant == 1) ? m_pend : 3'b000;
    m_ovr = |(ev & m_pend & ~taken);
    m_err = wr & m_busy;
    if (wr && !m_busy) begin
      m_busy = 1'b1;
      m_buf  = wd;
    end else if (m_cur == 2) begin
      m_busy = 1'b0;
    end
    m_pend = (m_pend & ~taken) | ev;
    if (grant == 1) m_snap = taken;
    if (grant != 0) begin
      m_wait     = 2;
      m_last_can = (grant == 1);
    end
    m_cur   = grant;
    m_irq_n = ~(rq[15] & (|(rq[6:4] & rq[2:0])));
  endtask

  function automatic logic [15:0] exp_vec();
    logic [6:0] d;
    d = {m_buf[15], m_buf[6:4], m_buf[2:0]};
    return {(m_cur == 1), (m_cur == 1) ? m_snap : 3'b000, (m_cur == 2),
            (m_cur == 2) ? d : 7'b0, m_busy, m_err, m_ovr, m_irq_n};
  endfunction

  task automatic tick(input logic [2:0] ev, input logic wr,
                      input logic [15:0] wd, input logic [15:0] rq);
    {ev_status, ev_suctra, ev_sucrec} = ev;
    cpu_wr = wr; cpu_wdata = wd; reg_q = rq;
    @(posedge clk);
    model_edge(ev, wr, wd, rq);
    #1;
    {ev_status, ev_suctra, ev_sucrec} = 3'b000;
    cpu_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (act !== 16'h0001) begin fails++; $display("FAIL reset_state: got %h expected %h", act, 16'h0001); end
    tick(3'b100, 1'b0, 16'h0, 16'h8011);
    tick(3'b000, 1'b0, 16'h0, 16'h8011);
    checks++;
    if (can !== 1'b1 || irq_n !== 1'b0) begin fails++; $display("FAIL reset_pre_grant: got can=%b irq_n=%b expected can=1 irq_n=0", can, irq_n); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act !== 16'h0001) begin fails++; $display("FAIL reset_midgrant: got %h expected %h", act, 16'h0001); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(3'b000, 1'b0, 16'h0, 16'h0);
      checks++;
      if (can !== 1'b0 || act !== exp_vec()) begin fails++; $display("FAIL reset_pend_lost c%0d: got %h expected %h", i, act, exp_vec()); end
    end
  endtask

  task automatic test_single_event();
    do_reset();
    tick(3'b010, 1'b0, 16'h0, 16'h0);
    checks++;
    if (can !== 1'b0) begin fails++; $display("FAIL single_early: got can=%b expected 0", can); end
    tick(3'b000, 1'b0, 16'h0, 16'h0);
    checks++;
    if ({can, irqstatusc, irqsuctrac, irqsucrecc, cpu} !== 5'b10100) begin
      fails++; $display("FAIL single_grant: got %b expected 10100", {can, irqstatusc, irqsuctrac, irqsucrecc, cpu});
    end
    tick(3'b000, 1'b0, 16'h0, 16'h0);
    checks++;
    if (act !== exp_vec() || can !== 1'b0) begin fails++; $display("FAIL single_gap: got %h expected %h", act, exp_vec()); end
  endtask

  task automatic test_contention();
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b00; seq[3] = 2'b01;
    do_reset();
    tick(3'b100, 1'b1, 16'h0042, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick(3'b000, 1'b0, 16'h0, 16'h0);
      checks++;
      if ({can, cpu} !== seq[i] || act !== exp_vec()) begin
        fails++; $display("FAIL contention c%0d: got can/cpu=%b vec=%h expected %b vec=%h", i, {can, cpu}, act, seq[i], exp_vec());
      end
    end
  endtask

  task automatic test_overrun();
    int n_ovr, n_can;
    logic saw_status;
    n_ovr = 0; n_can = 0; saw_status = 1'b0;
    do_reset();
    tick(3'b000, 1'b1, 16'h8070, 16'h0);
    tick(3'b000, 1'b0, 16'h0, 16'h0);
    checks++;
    if (cpu !== 1'b1) begin fails++; $display("FAIL overrun_cpu_gnt: got cpu=%b expected 1", cpu); end
    for (int i = 0; i < 8; i++) begin
      tick((i < 2) ? 3'b100 : 3'b000, 1'b0, 16'h0, 16'h0);
      n_ovr += int'(ev_ovr);
      n_can += int'(can);
      if (can && irqstatusc) saw_status = 1'b1;
      checks++;
      if (act !== exp_vec()) begin fails++; $display("FAIL overrun_vec c%0d: got %h expected %h", i, act, exp_vec()); end
    end
    checks++;
    if (n_ovr != 1 || n_can != 1 || !saw_status) begin
      fails++; $display("FAIL overrun_counts: got ovr=%0d can=%0d status=%b expected 1 1 1", n_ovr, n_can, saw_status);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(3'b000, 1'b1, 16'h8071, 16'h0);
    checks++;
    if (cpu_busy !== 1'b1 || cpu_err !== 1'b0) begin fails++; $display("FAIL bp_first: got busy=%b err=%b expected 1 0", cpu_busy, cpu_err); end
    tick(3'b000, 1'b1, 16'h1234, 16'h0);
    checks++;
    if ({cpu_err, cpu, onoffnin, iestatusp, iesuctrap, iesucrecp, irqstatusp, irqsuctrap, irqsucrecp} !== 9'b11_1111_001) begin
      fails++; $display("FAIL bp_commit: got %b expected 111111001",
        {cpu_err, cpu, onoffnin, iestatusp, iesuctrap, iesucrecp, irqstatusp, irqsuctrap, irqsucrecp});
    end
    tick(3'b000, 1'b0, 16'h0, 16'h0);
    checks++;
    if ({cpu_err, cpu, cpu_busy} !== 3'b000 || act !== exp_vec()) begin
      fails++; $display("FAIL bp_release: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_irq();
    logic [15:0] rq  [4];
    logic        exp [4];
    rq[0] = 16'h8011; exp[0] = 1'b0;
    rq[1] = 16'h0011; exp[1] = 1'b1;
    rq[2] = 16'h8010; exp[2] = 1'b1;
    rq[3] = 16'h8044; exp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(3'b000, 1'b0, 16'h0, rq[i]);
      checks++;
      if (irq_n !== exp[i]) begin fails++; $display("FAIL irq %h: got irq_n=%b expected %b", rq[i], irq_n, exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [2:0] ev;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ev = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      tick(ev, ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom));
      checks++;
      if (act !== exp_vec() || (can && cpu)) begin
        fails++; $display("FAIL random c%0d: got %h expected %h", i, act, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_contention();
    test_overrun();
    test_back_to_back();
    test_irq();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
